// File: rtl/sdrc_wb_arb_pkg.sv
// Shared types and the round-robin helper for the SDRAM
// Wishbone arbiter.
package sdrc_wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      ABORT
   } arb_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // First set bit of req at or after ptr, wrapping modulo n (n <= 8).
   function automatic logic [7:0] rr_pick(
      input logic [7:0] req,
      input logic [2:0] ptr,
      input int         n = 8
   );
      logic [7:0] r;
      logic [2:0] k;
      logic       hit;
      r   = '0;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < n && !hit) begin
            k = 3'((int'(ptr) + i) % n);
            if (req[k]) begin
               r[k] = 1'b1;
               hit  = 1'b1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sdrc_wb_rr_sel.sv
// Combinational round-robin picker: request vector and start
// pointer in, one-hot winner and its index out.
module sdrc_wb_rr_sel
   import sdrc_wb_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   logic [7:0] w_pick;

   always_comb begin
      w_pick  = rr_pick(8'(i_req), 3'(i_ptr), N);
      o_valid = |w_pick;
      o_gnt   = '0;
      o_idx   = '0;
      for (int i = 0; i < N; i++) begin
         o_gnt[i] = w_pick[i];
         if (w_pick[i]) o_idx = IW'(i);
      end
   end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of sdrc_top, holding each
// grant for a whole cycle and aborting stalled accesses.
module sdrc_wb_arbiter
   import sdrc_wb_arb_pkg::*;
#(
   parameter int NUM_M   = 2,
   parameter int AW      = 26,
   parameter int DW      = 32,
   parameter int SW      = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic [NUM_M-1:0]    m_cyc_i,
   input  logic [NUM_M-1:0]    m_stb_i,
   input  logic [NUM_M-1:0]    m_we_i,
   input  logic [NUM_M*AW-1:0] m_addr_i,
   input  logic [NUM_M*DW-1:0] m_dat_i,
   input  logic [NUM_M*SW-1:0] m_sel_i,
   input  logic [NUM_M*3-1:0]  m_cti_i,
   output logic [NUM_M-1:0]    m_ack_o,
   output logic [NUM_M-1:0]    m_err_o,
   output logic [DW-1:0]       m_dat_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic [AW-1:0]       s_addr_o,
   output logic [DW-1:0]       s_dat_o,
   output logic [SW-1:0]       s_sel_o,
   output logic [2:0]          s_cti_o,
   input  logic                s_ack_i,
   input  logic [DW-1:0]       s_dat_i,
   output logic [NUM_M-1:0]    gnt_o
);

   localparam int IW = $clog2(NUM_M);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WD_MAX  = '1;

   arb_state_t       r_state;
   logic [NUM_M-1:0] r_gnt;
   logic [IW-1:0]    r_gidx;
   logic [IW-1:0]    r_rr_ptr;
   logic [CW-1:0]    r_wd_cnt;
   logic [NUM_M-1:0] r_err;

   arb_state_t       w_nxt_state;
   logic [NUM_M-1:0] w_nxt_gnt;
   logic [IW-1:0]    w_nxt_gidx;
   logic [IW-1:0]    w_nxt_ptr;
   logic [CW-1:0]    w_nxt_wd;
   logic [NUM_M-1:0] w_nxt_err;

   logic [NUM_M-1:0] w_sel_gnt;
   logic [IW-1:0]    w_sel_idx;
   logic             w_sel_valid;
   logic [IW-1:0]    w_ptr_inc;
   logic             w_act;
   logic             w_cyc_g;
   logic             w_stall;
   logic             w_expire;

   sdrc_wb_rr_sel #(
      .N  (NUM_M),
      .IW (IW)
   ) u_sel (
      .i_req   (m_cyc_i),
      .i_ptr   (r_rr_ptr),
      .o_gnt   (w_sel_gnt),
      .o_idx   (w_sel_idx),
      .o_valid (w_sel_valid)
   );

   // Slave side is a pure mux of the registered grant.
   always_comb begin
      w_act    = (r_state == GRANT);
      w_cyc_g  = m_cyc_i[r_gidx];
      s_cyc_o  = w_act & w_cyc_g;
      s_stb_o  = w_act & m_stb_i[r_gidx];
      s_we_o   = w_act & m_we_i[r_gidx];
      s_addr_o = w_act ? m_addr_i[r_gidx*AW +: AW] : '0;
      s_dat_o  = w_act ? m_dat_i[r_gidx*DW +: DW] : '0;
      s_sel_o  = w_act ? m_sel_i[r_gidx*SW +: SW] : '0;
      s_cti_o  = w_act ? m_cti_i[r_gidx*3 +: 3] : CTI_CLASSIC;
      m_ack_o  = w_act ? (r_gnt & {NUM_M{s_ack_i}}) : '0;
      m_dat_o  = s_dat_i;
      m_err_o  = r_err;
      gnt_o    = r_gnt;
      w_stall  = s_stb_o & ~s_ack_i;
      w_expire = w_stall & (r_wd_cnt == WD_LAST);
      w_ptr_inc = (r_gidx == IW'(NUM_M - 1)) ? '0 : r_gidx + 1'b1;
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_gnt   = r_gnt;
      w_nxt_gidx  = r_gidx;
      w_nxt_ptr   = r_rr_ptr;
      w_nxt_wd    = '0;
      w_nxt_err   = '0;
      unique case (r_state)
         IDLE: begin
            if (w_sel_valid) begin
               w_nxt_state = GRANT;
               w_nxt_gnt   = w_sel_gnt;
               w_nxt_gidx  = w_sel_idx;
            end
         end
         GRANT: begin
            // Release beats expiry; ack clears the count before expiry.
            if (!w_cyc_g) begin
               w_nxt_state = IDLE;
               w_nxt_gnt   = '0;
               w_nxt_ptr   = w_ptr_inc;
            end else if (w_expire) begin
               w_nxt_state = ABORT;
               w_nxt_err   = r_gnt;
            end else if (w_stall) begin
               w_nxt_wd = (r_wd_cnt == WD_MAX) ? r_wd_cnt
                                               : r_wd_cnt + 1'b1;
            end
         end
         ABORT: begin
            if (!w_cyc_g) begin
               w_nxt_state = IDLE;
               w_nxt_gnt   = '0;
               w_nxt_ptr   = w_ptr_inc;
            end
         end
         default: begin
            w_nxt_state = IDLE;
            w_nxt_gnt   = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state  <= IDLE;
         r_gnt    <= '0;
         r_gidx   <= '0;
         r_rr_ptr <= '0;
         r_wd_cnt <= '0;
         r_err    <= '0;
      end else begin
         r_state  <= w_nxt_state;
         r_gnt    <= w_nxt_gnt;
         r_gidx   <= w_nxt_gidx;
         r_rr_ptr <= w_nxt_ptr;
         r_wd_cnt <= w_nxt_wd;
         r_err    <= w_nxt_err;
      end
   end

endmodule
